simon_round_ctrl: RTL and testbench

Round sequencer for the Simon Says game. It plays back the stored colour sequence one step at a time, then collects player button presses. It drives each press and the expected step index into the `verify_input` checker, and advances, wins or loses based on the checker's `result`. It sits between the button front end, the display driver and `verify_input`, and owns no sequence storage itself.

---
 rtl/simon_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_simon_round_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_ctrl.sv
// Simon Says round sequencer: plays back the stored sequence, collects presses,
// and steps through rounds using the external verify_input result.
module simon_round_ctrl #(
  parameter int MAX_ROUND      = 32,
  parameter int SHOW_CYCLES    = 50,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [3:0] btn_code,
  input  logic       ver_result,
  output logic [3:0] ver_input,
  output logic [4:0] ver_index,
  output logic       show_valid,
  output logic [4:0] show_index,
  output logic [5:0] round_num,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic [2:0] state_dbg
);

  // Handshake: start and btn_valid are single-cycle pulses with no ready; they
  // are consumed only in the states that accept them and silently dropped elsewhere.

  localparam int CMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CMAX    = (CMAX_SG > TIMEOUT_CYCLES) ? CMAX_SG : TIMEOUT_CYCLES;
  localparam int CW      = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SHOW_LAST    = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [5:0]    LEN_MAX      = 6'(MAX_ROUND);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHOW_ON    = 3'd1,
    SHOW_OFF   = 3'd2,
    WAIT_IN    = 3'd3,
    CHECK      = 3'd4,
    ROUND_DONE = 3'd5,
    WIN        = 3'd6,
    LOSE       = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    len_q, len_d;
  logic [4:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ver_input_q, ver_input_d;
  logic          step_last;

  assign step_last = ({1'b0, step_q} == (len_q - 6'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      ver_input_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      ver_input_q <= ver_input_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    ver_input_d = ver_input_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = SHOW_ON;
          len_d   = 6'd1;
          step_d  = '0;
          cnt_d   = '0;
        end
      end
      SHOW_ON: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = SHOW_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SHOW_OFF: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (step_last) begin
            step_d  = '0;
            state_d = WAIT_IN;
          end else begin
            step_d  = step_q + 5'd1;
            state_d = SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_IN: begin
        // A press in the final timeout cycle still wins over the timeout.
        if (btn_valid) begin
          ver_input_d = btn_code;
          state_d     = CHECK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = LOSE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CHECK: begin
        if (!ver_result) begin
          state_d = LOSE;
        end else if (!step_last) begin
          step_d  = step_q + 5'd1;
          cnt_d   = '0;
          state_d = WAIT_IN;
        end else if (len_q == LEN_MAX) begin
          state_d = WIN;
        end else begin
          len_d   = len_q + 6'd1;
          step_d  = '0;
          cnt_d   = '0;
          state_d = ROUND_DONE;
        end
      end
      ROUND_DONE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SHOW_ON;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ver_input  = ver_input_q;
  assign ver_index  = (state_q == IDLE) ? 5'd0 : step_q;
  assign show_valid = (state_q == SHOW_ON);
  assign show_index = (state_q == SHOW_ON) ? step_q : 5'd0;
  assign round_num  = (state_q == IDLE) ? 6'd0 : len_q;
  assign busy       = (state_q != IDLE) && (state_q != WIN) && (state_q != LOSE);
  assign win        = (state_q == WIN);
  assign lose       = (state_q == LOSE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: scripted and randomized games against a game-level
// model of playback timing, press handling and outcomes, with sequence {1,3,2}.
module tb_simon_round_ctrl;

  localparam int MAXR = 3;
  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       reset, start, btn_valid, ver_result;
  logic [3:0] btn_code, ver_input;
  logic [4:0] ver_index, show_index;
  logic       show_valid, busy, win, lose;
  logic [5:0] round_num;
  logic [2:0] state_dbg;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] last_code;
  logic [4:0] exp_q[$];
  logic [3:0] code_q[$];

  always #5 clk = ~clk;

  simon_round_ctrl #(
    .MAX_ROUND(MAXR), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid),
    .btn_code(btn_code), .ver_result(ver_result), .ver_input(ver_input),
    .ver_index(ver_index), .show_valid(show_valid), .show_index(show_index),
    .round_num(round_num), .busy(busy), .win(win), .lose(lose),
    .state_dbg(state_dbg)
  );

  function automatic logic [3:0] seq_at(input int i);
    case (i)
      0:       seq_at = 4'd1;
      1:       seq_at = 4'd3;
      2:       seq_at = 4'd2;
      default: seq_at = 4'd0;
    endcase
  endfunction

  // Behavioural verify_input: combinational compare against the stored sequence.
  assign ver_result = (ver_index < 5'd3) && (ver_input == seq_at(int'(ver_index)));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({ver_input, ver_index, show_valid, show_index, round_num, busy, win, lose, state_dbg} !== '0) begin
      failures++;
      $display("FAIL %s: vin=%0h vidx=%0d sv=%b sidx=%0d rn=%0d busy=%b win=%b lose=%b st=%0d, required all 0",
               name, ver_input, ver_index, show_valid, show_index, round_num, busy, win, lose, state_dbg);
    end
    last_code = 4'd0;
    exp_q.delete();
    code_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || show_valid !== 1'b1 || round_num !== 6'd1 || win !== 1'b0 ||
        lose !== 1'b0 || ver_index !== 5'd0) begin
      failures++;
      $display("FAIL start: busy=%b sv=%b rn=%0d win=%b lose=%b vidx=%0d, required 1 1 1 0 0 0",
               busy, show_valid, round_num, win, lose, ver_index);
    end
  endtask

  // Entered on the first SHOW_ON cycle; returns on the first WAIT_IN cycle.
  task automatic playback(input int n, input bit noise);
    for (int k = 0; k < n; k++) exp_q.push_back(5'(k));
    for (int k = 0; k < n; k++) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      for (int c = 0; c < SHOW + GAP; c++) begin
        checks++;
        if (c < SHOW) begin
          if (show_valid !== 1'b1 || show_index !== e || busy !== 1'b1 || ver_index !== e) begin
            failures++;
            $display("FAIL show_on: round %0d step %0d cyc %0d sv=%b sidx=%0d vidx=%0d busy=%b, required sv=1 idx=%0d busy=1",
                     n, k, c, show_valid, show_index, ver_index, busy, e);
          end
        end else begin
          if (show_valid !== 1'b0 || busy !== 1'b1 || round_num !== 6'(n)) begin
            failures++;
            $display("FAIL show_gap: round %0d step %0d cyc %0d sv=%b busy=%b rn=%0d, required sv=0 busy=1 rn=%0d",
                     n, k, c, show_valid, busy, round_num, n);
          end
        end
        if (noise) begin
          btn_valid = 1'($urandom_range(0, 1));
          btn_code  = 4'($urandom_range(0, 15));
          start     = 1'($urandom_range(0, 1));
        end
        tick();
        btn_valid = 1'b0;
        start     = 1'b0;
      end
    end
    checks++;
    if (ver_input !== last_code || ver_index !== 5'd0 || busy !== 1'b1 || show_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_in_entry: vin=%0h vidx=%0d busy=%b sv=%b, required vin=%0h vidx=0 busy=1 sv=0",
               ver_input, ver_index, busy, show_valid, last_code);
    end
  endtask

  // kind per step: 0 correct press, 1 wrong press, 2 no press (timeout).
  task automatic run_game(input bit rnd, input bit noise, input int bad_r, input int bad_s,
                          input int bad_kind, input int delay_fixed);
    do_start();
    playback(1, noise);
    for (int r = 1; r <= MAXR; r++) begin
      for (int s = 0; s < r; s++) begin
        int kind, delay, pick;
        logic [3:0] code;
        if (rnd) begin
          pick  = $urandom_range(0, 19);
          kind  = (pick < 2) ? 1 : ((pick == 2) ? 2 : 0);
          delay = $urandom_range(0, TO - 1);
        end else begin
          kind  = (r == bad_r && s == bad_s) ? bad_kind : 0;
          delay = delay_fixed;
        end
        if (kind == 2) begin
          repeat (TO - 1) tick();
          checks++;
          if (lose !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: lose=%b busy=%b after %0d idle cycles, required lose=0 busy=1",
                     lose, busy, TO - 1);
          end
          tick();
          checks++;
          if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || round_num !== 6'(r)) begin
            failures++;
            $display("FAIL timeout: lose=%b busy=%b win=%b rn=%0d, required lose=1 busy=0 win=0 rn=%0d",
                     lose, busy, win, round_num, r);
          end
          return;
        end
        code = (kind == 1) ? 4'(seq_at(s) + 4'($urandom_range(1, 15))) : seq_at(s);
        repeat (delay) tick();
        btn_valid = 1'b1;
        btn_code  = code;
        tick();
        btn_valid = 1'b0;
        code_q.push_back(code);
        last_code = code;
        begin
          logic [3:0] exp_code;
          exp_code = code_q.pop_front();
          checks++;
          if (ver_input !== exp_code || busy !== 1'b1 || lose !== 1'b0) begin
            failures++;
            $display("FAIL press_latch: vin=%0h busy=%b lose=%b (delay %0d), required vin=%0h busy=1 lose=0",
                     ver_input, busy, lose, delay, exp_code);
          end
        end
        tick();
        checks++;
        if (kind == 1) begin
          if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || round_num !== 6'(r)) begin
            failures++;
            $display("FAIL wrong_press: lose=%b busy=%b win=%b rn=%0d, required lose=1 busy=0 win=0 rn=%0d",
                     lose, busy, win, round_num, r);
          end
          return;
        end else if (s < r - 1) begin
          if (busy !== 1'b1 || lose !== 1'b0 || ver_index !== 5'(s + 1) || show_valid !== 1'b0) begin
            failures++;
            $display("FAIL next_step: busy=%b lose=%b vidx=%0d sv=%b, required busy=1 lose=0 vidx=%0d sv=0",
                     busy, lose, ver_index, show_valid, s + 1);
          end
        end else if (r == MAXR) begin
          if (win !== 1'b1 || busy !== 1'b0 || lose !== 1'b0 || round_num !== 6'(MAXR)) begin
            failures++;
            $display("FAIL win: win=%b busy=%b lose=%b rn=%0d, required win=1 busy=0 lose=0 rn=%0d",
                     win, busy, lose, round_num, MAXR);
          end
          return;
        end else begin
          if (round_num !== 6'(r + 1) || busy !== 1'b1 || show_valid !== 1'b0 || ver_index !== 5'd0) begin
            failures++;
            $display("FAIL round_done: rn=%0d busy=%b sv=%b vidx=%0d, required rn=%0d busy=1 sv=0 vidx=0",
                     round_num, busy, show_valid, ver_index, r + 1);
          end
          repeat (GAP) tick();
          playback(r + 1, noise);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_code = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_win();
    run_game(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_wrong_input();
    run_game(1'b0, 1'b0, 2, 1, 1, 3);
  endtask

  task automatic test_timeout();
    run_game(1'b0, 1'b0, 1, 0, 2, 0);
  endtask

  task automatic test_late_press();
    run_game(1'b0, 1'b0, 0, 0, 0, TO - 1);
  endtask

  task automatic test_ignored_inputs();
    run_game(1'b0, 1'b1, 3, 1, 1, 1);
  endtask

  task automatic test_reset_mid_show();
    do_start();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("reset_mid_show");
  endtask

  task automatic test_reset_mid_check();
    do_start();
    playback(1, 1'b0);
    btn_valid = 1'b1;
    btn_code  = 4'd1;
    tick();
    btn_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("reset_mid_check");
  endtask

  task automatic test_random_games();
    for (int g = 0; g < 30; g++) run_game(1'b1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
  endtask

  initial begin
    last_code = 4'd0;
    test_reset();
    test_win();
    test_wrong_input();
    test_timeout();
    test_late_press();
    test_ignored_inputs();
    test_reset_mid_show();
    test_reset_mid_check();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
